// File: rtl/scan_sequencer.sv
// rtl/scan_sequencer.sv - line scan sequencer driving a 3-to-8 decoder address and enable strobe
module scan_sequencer #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               cont,
  input  logic [7:0]         mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic               adr0,
  output logic               adr1,
  output logic               adr2,
  output logic               E,
  output logic               busy,
  output logic               done
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SETUP  = 3'd1;
  localparam logic [2:0] ACTIVE = 3'd2;
  localparam logic [2:0] GUARD  = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  logic [2:0]         state, state_nxt;
  logic [2:0]         adr_q, adr_nxt;
  logic [DWELL_W-1:0] cnt, cnt_nxt;
  logic [7:0]         mask_q;
  logic [DWELL_W-1:0] dwell_q;
  logic               cont_q;
  logic               e_q, busy_q, done_q;
  logic [3:0]         next_line;

  // Lowest enabled line index; a zero mask never reaches the scan states.
  function automatic logic [2:0] lowest(input logic [7:0] m);
    lowest = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) lowest = i[2:0];
    end
  endfunction

  // Nearest enabled index strictly above cur, as {found, index}.
  function automatic logic [3:0] above(input logic [7:0] m, input logic [2:0] cur);
    above = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i] && (i > int'(cur))) above = {1'b1, i[2:0]};
    end
  endfunction

  assign next_line = above(mask_q, adr_q);

  // Next-state, next-address and dwell-counter decisions; stop wins in the scan states.
  always_comb begin
    state_nxt = state;
    adr_nxt   = adr_q;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (start) begin
          if (mask == 8'd0) begin
            state_nxt = DONE;
          end else begin
            state_nxt = SETUP;
            adr_nxt   = lowest(mask);
          end
        end
      end
      SETUP: begin
        if (stop) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = ACTIVE;
          cnt_nxt   = dwell_q;
        end
      end
      ACTIVE: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (cnt == '0) begin
          state_nxt = GUARD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      GUARD: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (next_line[3]) begin
          state_nxt = SETUP;
          adr_nxt   = next_line[2:0];
        end else if (cont_q) begin
          state_nxt = SETUP;
          adr_nxt   = lowest(mask_q);
        end else begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, address, counter and captured configuration; outputs are registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      adr_q   <= 3'd0;
      cnt     <= '0;
      mask_q  <= 8'd0;
      dwell_q <= '0;
      cont_q  <= 1'b0;
      e_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      adr_q <= adr_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && start) begin
        mask_q  <= mask;
        dwell_q <= dwell;
        cont_q  <= cont;
      end
      e_q    <= (state_nxt == ACTIVE);
      busy_q <= (state_nxt != IDLE);
      done_q <= (state_nxt == DONE);
    end
  end

  assign adr0 = adr_q[2];
  assign adr1 = adr_q[1];
  assign adr2 = adr_q[0];
  assign E    = e_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// tb/tb_scan_sequencer.sv - scoreboard bench for scan_sequencer
module tb_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stop, cont;
  logic [7:0] mask;
  logic [3:0] dwell;
  logic       adr0, adr1, adr2, E, busy, done;
  logic [2:0] adr;

  assign adr = {adr0, adr1, adr2};

  scan_sequencer #(.DWELL_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .cont(cont),
    .mask(mask), .dwell(dwell), .adr0(adr0), .adr1(adr1), .adr2(adr2),
    .E(E), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_done;
    logic [2:0] adr;
    int         len;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_strobe(input logic [2:0] a, input int len);
    exp_t e;
    e.is_done = 1'b0; e.adr = a; e.len = len;
    q.push_back(e);
  endtask

  task automatic push_done();
    exp_t e;
    e.is_done = 1'b1; e.adr = 3'd0; e.len = 0;
    q.push_back(e);
  endtask

  // Monitor: collects each E-high window and each done pulse and checks against the queue.
  int         win_len = 0;
  logic [2:0] win_adr = 3'd0;
  always @(negedge clk) begin
    exp_t e;
    if (E) begin
      if (win_len == 0) win_adr = adr;
      else check("strobe_adr_hold", int'(adr), int'(win_adr));
      win_len++;
    end else if (win_len > 0) begin
      if (q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_strobe: actual=adr %0d len %0d required=none", win_adr, win_len);
      end else begin
        e = q.pop_front();
        check("event_kind_strobe", int'(e.is_done), 0);
        check("strobe_adr", int'(win_adr), int'(e.adr));
        check("strobe_len", win_len, e.len);
      end
      win_len = 0;
    end
    if (done) begin
      if (q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_done: actual=1 required=0");
      end else begin
        e = q.pop_front();
        check("event_kind_done", int'(e.is_done), 1);
        check("done_busy", int'(busy), 1);
        check("done_e_low", int'(E), 0);
      end
    end
  end

  task automatic do_start(input logic [7:0] m, input logic [3:0] d, input logic c);
    @(negedge clk);
    mask = m; dwell = d; cont = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n;
    n = 0;
    while (busy && n < bound) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(busy), 0);
  endtask

  task automatic check_drained(input string name);
    @(negedge clk);
    @(negedge clk);
    check(name, q.size(), 0);
  endtask

  initial begin
    int  n;
    int  wins;
    logic prev_e;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; cont = 1'b0; mask = 8'd0; dwell = 4'd0;
    repeat (3) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_e", int'(E), 0);
    check("reset_done", int'(done), 0);
    check("reset_adr", int'(adr), 0);
    rst_n = 1'b1;

    // Full mask, dwell 0, single frame: done 25 cycles after the start cycle.
    for (int i = 0; i < 8; i++) push_strobe(i[2:0], 1);
    push_done();
    @(negedge clk);
    mask = 8'hFF; dwell = 4'd0; cont = 1'b0; start = 1'b1;
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      start = 1'b0;
      if (done) break;
    end
    check("done_latency", n, 25);
    @(negedge clk);
    check("busy_after_done", int'(busy), 0);
    check_drained("frame_ff_drained");

    // Sparse mask, dwell 3; reconfiguration and start while busy must be ignored.
    push_strobe(3'd2, 4); push_strobe(3'd5, 4); push_strobe(3'd7, 4);
    push_done();
    do_start(8'b1010_0100, 4'd3, 1'b0);
    check("busy_after_start", int'(busy), 1);
    mask = 8'hFF; dwell = 4'd0; cont = 1'b1; start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_idle("sparse_idle", 200);
    check_drained("sparse_drained");

    // Empty mask: straight to a one-cycle done, no strobes.
    push_done();
    @(negedge clk);
    mask = 8'd0; dwell = 4'd5; cont = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("empty_busy", int'(busy), 1);
    check("empty_done", int'(done), 1);
    @(negedge clk);
    check("empty_done_cleared", int'(done), 0);
    check("empty_busy_cleared", int'(busy), 0);
    check_drained("empty_drained");

    // Continuous 0,7,0,7,... then stop during the first ACTIVE cycle of the sixth window.
    push_strobe(3'd0, 2); push_strobe(3'd7, 2); push_strobe(3'd0, 2);
    push_strobe(3'd7, 2); push_strobe(3'd0, 2); push_strobe(3'd7, 1);
    do_start(8'h81, 4'd1, 1'b1);
    wins = 0; prev_e = 1'b0; n = 0;
    while (n < 300) begin
      if (E && !prev_e) wins++;
      prev_e = E;
      if (wins == 6) break;
      @(negedge clk);
      n++;
    end
    check("cont_windows_seen", wins, 6);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("stop_e", int'(E), 0);
    check("stop_busy", int'(busy), 0);
    check_drained("cont_drained");

    // Asynchronous reset between edges during ACTIVE.
    push_strobe(3'd0, 2);
    do_start(8'h01, 4'd7, 1'b0);
    n = 0;
    while (!E && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("reset_test_e_seen", int'(E), 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_e", int'(E), 0);
    check("async_busy", int'(busy), 0);
    check("async_done", int'(done), 0);
    check("async_adr", int'(adr), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    push_done();
    mask = 8'd0; start = 1'b1;
    @(posedge clk);
    #1;
    check("first_start_after_reset", int'(busy), 1);
    start = 1'b0;
    wait_idle("post_reset_idle", 10);
    check_drained("final_drained");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
